seq_divider_pw: RTL and testbench

- Parametrised multi-cycle restoring divider. Successor to the fixed 32-bit unsigned divider; adds configurable width, per-operation signed/unsigned mode and a valid/ready handshake on both sides.
- Divide-by-zero and signed-overflow results are defined.
- Sits between the capsule routing datapath (squash/normalisation) and any producer needing an integer quotient and remainder; one operation in flight.

---
 rtl/seq_divider_pw.sv | 131 +++++++++++++
 tb/tb_seq_divider_pw.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider_pw.sv
// Multi-cycle restoring divider, WIDTH-bit operands, optional signed mode, valid/ready on both sides.
// One bit of quotient per cycle; result presented WIDTH+1 cycles after accept and held until consumed.
module seq_divider_pw #(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_den;
  logic [CW-1:0]    r_cnt;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dz;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_remo;
  logic             r_dzo;

  logic             w_accept;
  logic             w_sgn;
  logic             w_dvd_neg;
  logic             w_dvs_neg;
  logic             w_dvs_zero;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;

  assign w_accept   = in_valid & in_ready;
  assign w_sgn      = in_signed & SIGNED_EN;
  assign w_dvd_neg  = w_sgn & dividend[WIDTH-1];
  assign w_dvs_neg  = w_sgn & divisor[WIDTH-1];
  assign w_dvs_zero = (divisor == '0);
  assign w_dvd_mag  = w_dvd_neg ? -dividend : dividend;
  assign w_dvs_mag  = w_dvs_neg ? -divisor : divisor;

  // Partial remainder keeps its carry-out bit so divisors above 2^(WIDTH-1) still work unsigned.
  assign w_shift = {r_rem, r_q[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_den});
  assign w_diff  = WIDTH'(w_shift - {1'b0, r_den});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Divide-by-zero still passes through FIX so its result appears one cycle after accept.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = w_dvs_zero ? FIX : CALC;
      CALC:    if (r_cnt == '0) w_next = FIX;
      FIX:     w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q     <= '0;
      r_rem   <= '0;
      r_den   <= '0;
      r_cnt   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
      r_quot  <= '0;
      r_remo  <= '0;
      r_dzo   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_neg_q <= w_dvd_neg ^ w_dvs_neg;
          r_neg_r <= w_dvd_neg;
          r_dz    <= w_dvs_zero;
          r_q     <= w_dvs_zero ? dividend : w_dvd_mag;
          r_den   <= w_dvs_mag;
          r_rem   <= '0;
          r_cnt   <= CW'(WIDTH-1);
        end
        CALC: begin
          r_rem <= w_ge ? w_diff : w_shift[WIDTH-1:0];
          r_q   <= {r_q[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt - 1'b1;
        end
        FIX: begin
          if (r_dz) begin
            r_quot <= '1;
            r_remo <= r_q;
            r_dzo  <= 1'b1;
          end else begin
            r_quot <= r_neg_q ? -r_q : r_q;
            r_remo <= r_neg_r ? -r_rem : r_rem;
            r_dzo  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = (r_state == IDLE);
  assign out_valid   = (r_state == DONE);
  assign busy        = (r_state != IDLE);
  assign quotient    = r_quot;
  assign remainder   = r_remo;
  assign div_by_zero = r_dzo;

endmodule

// File: tb/tb_seq_divider_pw.sv
// Directed and random checks of seq_divider_pw in three configurations against a scoreboard model.
module tb_seq_divider_pw;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // inst 0: WIDTH=32 signed-capable; inst 1: WIDTH=8 signed-capable; inst 2: WIDTH=32 SIGNED_EN=0
  logic        iv0, sg0, or0, ir0, ov0, dz0, bz0;
  logic [31:0] a0, b0, q0, r0;
  logic        iv1, sg1, or1, ir1, ov1, dz1, bz1;
  logic [7:0]  a1, b1, q1, r1;
  logic        iv2, sg2, or2, ir2, ov2, dz2, bz2;
  logic [31:0] a2, b2, q2, r2;

  seq_divider_pw #(.WIDTH(32), .SIGNED_EN(1'b1)) u0 (
    .clk(clk), .reset(reset), .in_valid(iv0), .in_ready(ir0), .in_signed(sg0),
    .dividend(a0), .divisor(b0), .out_valid(ov0), .out_ready(or0),
    .quotient(q0), .remainder(r0), .div_by_zero(dz0), .busy(bz0));
  seq_divider_pw #(.WIDTH(8), .SIGNED_EN(1'b1)) u1 (
    .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(ir1), .in_signed(sg1),
    .dividend(a1), .divisor(b1), .out_valid(ov1), .out_ready(or1),
    .quotient(q1), .remainder(r1), .div_by_zero(dz1), .busy(bz1));
  seq_divider_pw #(.WIDTH(32), .SIGNED_EN(1'b0)) u2 (
    .clk(clk), .reset(reset), .in_valid(iv2), .in_ready(ir2), .in_signed(sg2),
    .dividend(a2), .divisor(b2), .out_valid(ov2), .out_ready(or2),
    .quotient(q2), .remainder(r2), .div_by_zero(dz2), .busy(bz2));

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int wid(input int inst);
    return (inst == 1) ? 8 : 32;
  endfunction

  function automatic bit sgen(input int inst);
    return (inst != 2);
  endfunction

  // Reference: native 64-bit integer division on width-extended operands.
  function automatic void model(input int w, input bit sg, input logic [63:0] a, input logic [63:0] b,
                                output logic [63:0] q, output logic [63:0] r, output logic dz);
    logic [63:0] m;
    logic [63:0] ua, ub;
    longint      sa, sb2;
    m  = (64'd1 << w) - 64'd1;
    ua = a & m;
    ub = b & m;
    dz = 1'b0;
    if (ub == 64'd0) begin
      q  = m;
      r  = ua;
      dz = 1'b1;
    end else if (sg) begin
      sa  = $signed(ua << (64 - w)) >>> (64 - w);
      sb2 = $signed(ub << (64 - w)) >>> (64 - w);
      q   = 64'(sa / sb2) & m;
      r   = 64'(sa % sb2) & m;
    end else begin
      q = (ua / ub) & m;
      r = (ua % ub) & m;
    end
  endfunction

  task automatic set_in(input int inst, input logic v, input logic s, input logic [63:0] a, input logic [63:0] b);
    case (inst)
      0: begin iv0 = v; sg0 = s; a0 = a[31:0]; b0 = b[31:0]; end
      1: begin iv1 = v; sg1 = s; a1 = a[7:0];  b1 = b[7:0];  end
      default: begin iv2 = v; sg2 = s; a2 = a[31:0]; b2 = b[31:0]; end
    endcase
  endtask

  task automatic set_ordy(input int inst, input logic v);
    case (inst)
      0: or0 = v;
      1: or1 = v;
      default: or2 = v;
    endcase
  endtask

  task automatic get_out(input int inst, output logic ov, output logic ir, output logic bz,
                         output logic dz, output logic [63:0] q, output logic [63:0] r);
    case (inst)
      0: begin ov = ov0; ir = ir0; bz = bz0; dz = dz0; q = {32'd0, q0}; r = {32'd0, r0}; end
      1: begin ov = ov1; ir = ir1; bz = bz1; dz = dz1; q = {56'd0, q1}; r = {56'd0, r1}; end
      default: begin ov = ov2; ir = ir2; bz = bz2; dz = dz2; q = {32'd0, q2}; r = {32'd0, r2}; end
    endcase
  endtask

  task automatic start_op(input int inst, input logic s, input logic [63:0] a, input logic [63:0] b);
    exp_t e;
    int n;
    logic ov, ir, bz, dz;
    logic [63:0] q, r;
    n = 0;
    set_in(inst, 1'b1, s, a, b);
    get_out(inst, ov, ir, bz, dz, q, r);
    while (!ir && n < 100) begin
      tick();
      n++;
      get_out(inst, ov, ir, bz, dz, q, r);
    end
    chk("accept_ready", {63'd0, ir}, 64'd1);
    tick();
    set_in(inst, 1'b0, ~s, {$urandom, $urandom}, {$urandom, $urandom});
    model(wid(inst), s & sgen(inst), a, b, e.q, e.r, e.dz);
    e.lat = e.dz ? 1 : wid(inst) + 1;
    sb.push_back(e);
  endtask

  task automatic wait_valid(input int inst, output int lat);
    logic ov, ir, bz, dz;
    logic [63:0] q, r;
    lat = 0;
    get_out(inst, ov, ir, bz, dz, q, r);
    while (!ov && lat < 200) begin
      tick();
      lat++;
      get_out(inst, ov, ir, bz, dz, q, r);
    end
  endtask

  task automatic check_out(input int inst, input int lat, input string tag);
    exp_t e;
    logic ov, ir, bz, dz;
    logic [63:0] q, r;
    chk({tag, "_sb_depth"}, 64'(sb.size()), 64'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      get_out(inst, ov, ir, bz, dz, q, r);
      chk({tag, "_latency"}, 64'(lat), 64'(e.lat));
      chk({tag, "_quotient"}, q, e.q);
      chk({tag, "_remainder"}, r, e.r);
      chk({tag, "_dbz"}, {63'd0, dz}, {63'd0, e.dz});
    end
  endtask

  task automatic consume(input int inst, input string tag);
    logic ov, ir, bz, dz;
    logic [63:0] q, r;
    set_ordy(inst, 1'b1);
    tick();
    set_ordy(inst, 1'b0);
    get_out(inst, ov, ir, bz, dz, q, r);
    chk({tag, "_valid_drop"}, {63'd0, ov}, 64'd0);
  endtask

  task automatic run_op(input int inst, input logic s, input logic [63:0] a, input logic [63:0] b, input string tag);
    int lat;
    start_op(inst, s, a, b);
    wait_valid(inst, lat);
    check_out(inst, lat, tag);
    consume(inst, tag);
  endtask

  function automatic logic [63:0] pick(input int w);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    case ($urandom_range(0, 7))
      0:       return 64'd0;
      1:       return 64'd1 << (w - 1);
      2:       return m;
      3:       return 64'($urandom_range(0, 15));
      default: return {$urandom, $urandom} & m;
    endcase
  endfunction

  initial begin
    logic ov, ir, bz, dz;
    logic [63:0] q, r;
    int lat, n_ov, inst;
    reset = 1'b1;
    iv0 = 0; sg0 = 0; or0 = 0; a0 = 0; b0 = 0;
    iv1 = 0; sg1 = 0; or1 = 0; a1 = 0; b1 = 0;
    iv2 = 0; sg2 = 0; or2 = 0; a2 = 0; b2 = 0;
    tick();
    tick();
    get_out(0, ov, ir, bz, dz, q, r);
    chk("rst_in_ready", {63'd0, ir}, 64'd1);
    chk("rst_out_valid", {63'd0, ov}, 64'd0);
    chk("rst_busy", {63'd0, bz}, 64'd0);
    chk("rst_dbz", {63'd0, dz}, 64'd0);
    chk("rst_quotient", q, 64'd0);
    chk("rst_remainder", r, 64'd0);
    reset = 1'b0;
    tick();

    run_op(0, 1'b0, 64'd100, 64'd7, "u32_100_7");
    run_op(1, 1'b1, 64'hF9, 64'h02, "s8_m7_2");
    run_op(1, 1'b1, 64'h07, 64'hFE, "s8_7_m2");
    run_op(1, 1'b1, 64'h80, 64'hFF, "s8_min_m1");
    run_op(0, 1'b1, 64'd1234, 64'd0, "dz_signed");
    run_op(0, 1'b0, 64'd1234, 64'd0, "dz_unsigned");
    run_op(2, 1'b1, 64'hFFFF_FFFE, 64'd2, "noen_signed_req");
    run_op(0, 1'b0, 64'hFFFF_FFFF, 64'h8000_0001, "u32_big_den");

    // Backpressure: result must hold while inputs churn, then a same-cycle in_valid is deferred.
    start_op(0, 1'b0, 64'd1000, 64'd3);
    wait_valid(0, lat);
    check_out(0, lat, "bp");
    for (int i = 0; i < 10; i++) begin
      set_in(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom});
      tick();
      get_out(0, ov, ir, bz, dz, q, r);
      chk("bp_hold_quotient", q, 64'd333);
      chk("bp_hold_remainder", r, 64'd1);
      chk("bp_hold_valid", {63'd0, ov}, 64'd1);
      chk("bp_in_ready_low", {63'd0, ir}, 64'd0);
    end
    set_in(0, 1'b1, 1'b0, 64'd50, 64'd5);
    set_ordy(0, 1'b1);
    tick();
    set_ordy(0, 1'b0);
    get_out(0, ov, ir, bz, dz, q, r);
    chk("simul_valid_drop", {63'd0, ov}, 64'd0);
    chk("simul_ready_back", {63'd0, ir}, 64'd1);
    chk("simul_not_busy", {63'd0, bz}, 64'd0);
    begin
      exp_t e;
      model(32, 1'b0, 64'd50, 64'd5, e.q, e.r, e.dz);
      e.lat = 33;
      sb.push_back(e);
    end
    tick();
    set_in(0, 1'b0, 1'b0, 64'd0, 64'd0);
    get_out(0, ov, ir, bz, dz, q, r);
    chk("simul_accept_busy", {63'd0, bz}, 64'd1);
    wait_valid(0, lat);
    check_out(0, lat, "simul_50_5");
    consume(0, "simul_50_5");

    // Reset during CALC after five iterations.
    start_op(0, 1'b0, 64'h1234_5678, 64'd3);
    void'(sb.pop_back());
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    #2;
    get_out(0, ov, ir, bz, dz, q, r);
    chk("midrst_busy", {63'd0, bz}, 64'd0);
    chk("midrst_in_ready", {63'd0, ir}, 64'd1);
    reset = 1'b0;
    tick();
    get_out(0, ov, ir, bz, dz, q, r);
    chk("midrst_ready_next", {63'd0, ir}, 64'd1);
    n_ov = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      get_out(0, ov, ir, bz, dz, q, r);
      if (ov) n_ov++;
    end
    chk("midrst_no_output", 64'(n_ov), 64'd0);
    run_op(0, 1'b0, 64'hFFFF_FFFF, 64'd1, "after_rst");

    for (int k = 0; k < 1000; k++) begin
      inst = (k < 500) ? 0 : ((k < 750) ? 1 : 2);
      run_op(inst, 1'($urandom_range(0, 1)), pick(wid(inst)), pick(wid(inst)), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
